frame_store_responder: RTL and testbench

//  Responder end of the drawing-engine (de_*) memory interface: accepts word-addressed,

---
 rtl/frame_store_responder_pkg.sv | 18 +
 rtl/frame_store_responder_sram_rd_pipe.sv | 45 ++++
 rtl/frame_store_responder.sv | 145 ++++++++++++++
 tb/tb_frame_store_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_store_responder_pkg.sv
// Shared definitions for the frame-store responder: FSM encoding, request
// direction constants, the "no bytes enabled" mask and default widths.
package frame_store_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    ACK     = 2'd3
  } fsm_state_t;

  localparam logic       DE_RNW_READ    = 1'b1;
  localparam logic       DE_RNW_WRITE   = 1'b0;
  localparam logic [3:0] NBYTE_NONE     = 4'b1111;
  localparam int         DEFAULT_ADDR_W = 18;
  localparam int         DEFAULT_DATA_W = 32;

endpackage

// File: rtl/frame_store_responder_sram_rd_pipe.sv
// Read-latency tracker: counts down from the SRAM strobe to the cycle in which
// sram_rdata is valid and says which requester the returned word belongs to.
module sram_rd_pipe
  import frame_store_responder_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic start_vid,
  output logic capture_de,
  output logic capture_vid
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  logic             busy;
  logic             tag_vid;
  logic [CNT_W-1:0] cnt;

  // The count is loaded on the strobe edge, so it reaches zero exactly in the
  // cycle RD_LATENCY after the strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      tag_vid <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      tag_vid <= start_vid;
      cnt     <= CNT_W'(RD_LATENCY);
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign capture_de  = busy && (cnt == '0) && !tag_vid;
  assign capture_vid = busy && (cnt == '0) && tag_vid;

endmodule

// File: rtl/frame_store_responder.sv
// Frame-store responder: serves drawing-engine reads/writes and display reads
// on a single-port synchronous SRAM, alternating grants when both contend.
module frame_store_responder
  import frame_store_responder_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [DATA_W-1:0] de_w_data,
  output logic [DATA_W-1:0] de_r_data,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  fsm_state_t        state, state_next;
  logic              last_vid, last_vid_next;
  logic              de_ack_next, vid_ack_next;
  logic              cs_next, we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [3:0]        be_next;
  logic [DATA_W-1:0] wdata_next, de_r_data_next, vid_data_next;
  logic              grant_vid, grant_de;
  logic              pipe_start, pipe_vid;
  logic              capture_de, capture_vid;

  sram_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .start       (pipe_start),
    .start_vid   (pipe_vid),
    .capture_de  (capture_de),
    .capture_vid (capture_vid)
  );

  // Every output is a register; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_vid   <= 1'b0;
      de_ack     <= 1'b0;
      vid_ack    <= 1'b0;
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_be    <= '0;
      sram_wdata <= '0;
      de_r_data  <= '0;
      vid_data   <= '0;
    end else begin
      state      <= state_next;
      last_vid   <= last_vid_next;
      de_ack     <= de_ack_next;
      vid_ack    <= vid_ack_next;
      sram_cs    <= cs_next;
      sram_we    <= we_next;
      sram_addr  <= addr_next;
      sram_be    <= be_next;
      sram_wdata <= wdata_next;
      de_r_data  <= de_r_data_next;
      vid_data   <= vid_data_next;
    end
  end

  // Display wins a tie unless it had the previous grant.
  assign grant_vid = (state == IDLE) && vid_req && (!de_req || !last_vid);
  assign grant_de  = (state == IDLE) && de_req && !grant_vid;

  always_comb begin
    state_next     = state;
    last_vid_next  = last_vid;
    de_ack_next    = 1'b0;
    vid_ack_next   = 1'b0;
    cs_next        = 1'b0;
    we_next        = 1'b0;
    addr_next      = sram_addr;
    be_next        = '0;
    wdata_next     = sram_wdata;
    de_r_data_next = de_r_data;
    vid_data_next  = vid_data;
    pipe_start     = 1'b0;
    pipe_vid       = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_vid) begin
          last_vid_next = 1'b1;
          addr_next     = vid_addr;
          cs_next       = 1'b1;
          be_next       = 4'b1111;
          pipe_start    = 1'b1;
          pipe_vid      = 1'b1;
          state_next    = RD_WAIT;
        end else if (grant_de) begin
          last_vid_next = 1'b0;
          addr_next     = de_addr;
          if (de_rnw == DE_RNW_READ) begin
            cs_next    = 1'b1;
            be_next    = 4'b1111;
            pipe_start = 1'b1;
            state_next = RD_WAIT;
          end else begin
            // A fully masked write still completes the handshake but never strobes.
            cs_next     = (de_nbyte != NBYTE_NONE);
            we_next     = (de_nbyte != NBYTE_NONE);
            be_next     = ~de_nbyte;
            wdata_next  = de_w_data;
            de_ack_next = 1'b1;
            state_next  = WRITE;
          end
        end
      end
      WRITE: state_next = IDLE;
      RD_WAIT: begin
        if (capture_vid) begin
          vid_ack_next  = 1'b1;
          vid_data_next = sram_rdata;
          state_next    = ACK;
        end else if (capture_de) begin
          de_ack_next    = 1'b1;
          de_r_data_next = sram_rdata;
          state_next     = ACK;
        end
      end
      ACK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_store_responder.sv
// Directed bench for frame_store_responder with a behavioural two-cycle-latency
// byte-masked SRAM model; each scenario task checks its own results.
module tb_frame_store_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_req, de_ack, de_rnw;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_w_data, de_r_data;
  logic        vid_req, vid_ack;
  logic [17:0] vid_addr;
  logic [31:0] vid_data;
  logic        sram_cs, sram_we;
  logic [17:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata, sram_rdata;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] mem [logic [17:0]];
  int          wr_count [logic [17:0]];
  logic [31:0] rd_s1, rd_s2;
  logic        rd_v1 = 1'b0, rd_v2 = 1'b0;

  always #5 clk = ~clk;

  frame_store_responder #(.ADDR_W(18), .DATA_W(32), .RD_LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_addr    (de_addr),
    .de_nbyte   (de_nbyte),
    .de_rnw     (de_rnw),
    .de_w_data  (de_w_data),
    .de_r_data  (de_r_data),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_data   (vid_data),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_be    (sram_be),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // SRAM model: data is valid only in the cycle two after the strobe cycle.
  always @(posedge clk) begin
    logic [31:0] cur;
    rd_v1 <= 1'b0;
    if (sram_cs) begin
      cur = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
        mem[sram_addr] = cur;
        wr_count[sram_addr] = (wr_count.exists(sram_addr) ? wr_count[sram_addr] : 0) + 1;
      end else begin
        rd_s1 <= cur;
        rd_v1 <= 1'b1;
      end
    end
    rd_s2 <= rd_s1;
    rd_v2 <= rd_v1;
  end

  assign sram_rdata = rd_v2 ? rd_s2 : 32'hBAD0_BAD0;

  task automatic test_reset();
    rst = 1'b1; de_req = 1'b0; de_rnw = 1'b0; de_addr = '0; de_nbyte = 4'hF;
    de_w_data = '0; vid_req = 1'b0; vid_addr = '0;
    @(negedge clk); @(negedge clk);
    n_compared++; if (de_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_de_ack: got %b want 0", de_ack); end
    n_compared++; if (vid_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_vid_ack: got %b want 0", vid_ack); end
    n_compared++; if (sram_cs !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_cs: got %b want 0", sram_cs); end
    n_compared++; if (sram_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_we: got %b want 0", sram_we); end
    n_compared++; if (sram_addr !== 18'h0) begin n_mismatched++; $display("[TB] FAIL reset_addr: got %h want 0", sram_addr); end
    n_compared++; if (sram_be !== 4'h0) begin n_mismatched++; $display("[TB] FAIL reset_be: got %h want 0", sram_be); end
    n_compared++; if (de_r_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", de_r_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00010; de_nbyte = 4'b1110; de_w_data = 32'h000000A5;
    @(negedge clk);
    n_compared++; if (sram_cs !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_cs: got %b want 1", sram_cs); end
    n_compared++; if (sram_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_we: got %b want 1", sram_we); end
    n_compared++; if (sram_addr !== 18'h00010) begin n_mismatched++; $display("[TB] FAIL wr_addr: got %h want 00010", sram_addr); end
    n_compared++; if (sram_be !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL wr_be: got %b want 0001", sram_be); end
    n_compared++; if (de_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_ack: got %b want 1", de_ack); end
    de_req = 1'b0;
    @(negedge clk);
    n_compared++; if (de_ack !== 1'b0 || sram_cs !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wr_ack_one_cycle: ack %b cs %b want 0 0", de_ack, sram_cs); end
    n_compared++; if (mem[18'h00010] !== 32'h000000A5) begin n_mismatched++; $display("[TB] FAIL wr_mem: got %h want 000000a5", mem[18'h00010]); end
  endtask

  task automatic test_read();
    de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00010; de_nbyte = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_compared++; if (sram_cs !== 1'b1 || sram_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rd_strobe: cs %b we %b want 1 0", sram_cs, sram_we); end
      end
      n_compared++; if (de_ack !== (k == 4)) begin n_mismatched++; $display("[TB] FAIL rd_ack_cycle%0d: got %b want %b", k, de_ack, (k == 4)); end
      if (k == 4) begin
        n_compared++; if (de_r_data !== 32'h000000A5) begin n_mismatched++; $display("[TB] FAIL rd_data: got %h want 000000a5", de_r_data); end
        de_req = 1'b0;
      end
    end
    n_compared++; if (de_r_data !== 32'h000000A5) begin n_mismatched++; $display("[TB] FAIL rd_data_hold: got %h want 000000a5", de_r_data); end
  endtask

  task automatic test_arbitration();
    int   n_acks;
    logic seq [4];
    logic [31:0] first_vid_data;
    n_acks = 0; first_vid_data = '0;
    rst = 1'b1;
    de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00020; de_nbyte = 4'b0000; de_w_data = 32'h12345678;
    vid_req = 1'b1; vid_addr = 18'h00010;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40 && n_acks < 4; c++) begin
      @(negedge clk);
      if (de_ack && vid_ack) begin
        n_compared++; n_mismatched++;
        $display("[TB] FAIL arb_double_ack: de_ack %b vid_ack %b want one at a time", de_ack, vid_ack);
      end
      if (de_ack || vid_ack) begin
        if (vid_ack && first_vid_data == '0) first_vid_data = vid_data;
        seq[n_acks] = vid_ack;
        n_acks++;
      end
    end
    de_req = 1'b0; vid_req = 1'b0;
    n_compared++; if (n_acks !== 4) begin n_mismatched++; $display("[TB] FAIL arb_ack_count: got %0d want 4", n_acks); end
    for (int i = 0; i < n_acks; i++) begin
      n_compared++; if (seq[i] !== ((i % 2) == 0)) begin n_mismatched++; $display("[TB] FAIL arb_order%0d: vid %b want %b", i, seq[i], ((i % 2) == 0)); end
    end
    n_compared++; if (first_vid_data !== 32'h000000A5) begin n_mismatched++; $display("[TB] FAIL arb_vid_data: got %h want 000000a5", first_vid_data); end
    @(negedge clk); @(negedge clk);
    n_compared++; if (mem[18'h00020] !== 32'h12345678) begin n_mismatched++; $display("[TB] FAIL arb_de_write: got %h want 12345678", mem[18'h00020]); end
  endtask

  task automatic test_masked_write();
    de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00010; de_nbyte = 4'b1111; de_w_data = 32'hFFFFFFFF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_compared++; if (de_ack !== (k == 1)) begin n_mismatched++; $display("[TB] FAIL mask_ack_cycle%0d: got %b want %b", k, de_ack, (k == 1)); end
      n_compared++; if (sram_cs !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mask_cs_cycle%0d: got %b want 0", k, sram_cs); end
      if (k == 1) de_req = 1'b0;
    end
    n_compared++; if (mem[18'h00010] !== 32'h000000A5) begin n_mismatched++; $display("[TB] FAIL mask_mem: got %h want 000000a5", mem[18'h00010]); end
  endtask

  task automatic test_reset_mid_read();
    int n_acks;
    n_acks = 0;
    de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00020; de_nbyte = 4'b1111;
    @(negedge clk);
    n_compared++; if (sram_cs !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstrd_strobe: got %b want 1", sram_cs); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_compared++; if (de_ack !== 1'b0 || vid_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstrd_acks: de %b vid %b want 0 0", de_ack, vid_ack); end
    n_compared++; if (sram_cs !== 1'b0 || sram_we !== 1'b0 || sram_be !== 4'h0) begin n_mismatched++; $display("[TB] FAIL rstrd_sram: cs %b we %b be %h want 0", sram_cs, sram_we, sram_be); end
    n_compared++; if (sram_addr !== 18'h0 || de_r_data !== 32'h0 || vid_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rstrd_regs: addr %h rdata %h vdata %h want 0", sram_addr, de_r_data, vid_data); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (de_ack) begin
        n_acks++;
        n_compared++; if (de_r_data !== 32'h12345678) begin n_mismatched++; $display("[TB] FAIL rstrd_data: got %h want 12345678", de_r_data); end
        de_req = 1'b0;
      end
    end
    n_compared++; if (n_acks !== 1) begin n_mismatched++; $display("[TB] FAIL rstrd_ack_count: got %0d want 1", n_acks); end
  endtask

  task automatic test_back_to_back();
    int idx, pulses;
    idx = 0; pulses = 0;
    wr_count.delete();
    de_req = 1'b1; de_rnw = 1'b0; de_nbyte = 4'b0000;
    de_addr = 18'h0; de_w_data = 32'hC0DE0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (sram_cs) pulses++;
      if (de_ack) begin
        idx++;
        if (idx == 4) de_req = 1'b0;
        de_addr = 18'(idx); de_w_data = 32'hC0DE0000 + 32'(idx);
      end
    end
    de_req = 1'b0;
    n_compared++; if (pulses !== 4) begin n_mismatched++; $display("[TB] FAIL b2b_pulses: got %0d want 4", pulses); end
    n_compared++; if (idx !== 4) begin n_mismatched++; $display("[TB] FAIL b2b_acks: got %0d want 4", idx); end
    for (int a = 0; a < 4; a++) begin
      n_compared++;
      if (!wr_count.exists(18'(a)) || wr_count[18'(a)] !== 1) begin
        n_mismatched++; $display("[TB] FAIL b2b_writes_addr%0d: got %0d want 1", a, wr_count.exists(18'(a)) ? wr_count[18'(a)] : 0);
      end
      n_compared++;
      if (!mem.exists(18'(a)) || mem[18'(a)] !== 32'hC0DE0000 + 32'(a)) begin
        n_mismatched++; $display("[TB] FAIL b2b_mem_addr%0d: got %h want %h", a, mem.exists(18'(a)) ? mem[18'(a)] : 32'h0, 32'hC0DE0000 + 32'(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_masked_write();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
